// File: rtl/playfield_render_ctrl_pkg.sv
// Shared constants, palette and fetch FSM states for the playfield renderer.
package playfield_render_ctrl_pkg;

  localparam int X0      = 104;
  localparam int Y0      = 17;
  localparam int PITCH   = 26;
  localparam int COLS    = 14;
  localparam int ROWS    = 22;
  localparam int FETCH_H = 8;

  localparam int IDX_W  = 5;
  localparam int SUB_W  = 5;
  localparam int FCOL_W = 4;

  localparam logic [7:0] GRID_COLOR = 8'hFF;

  // RGB332 colour per board cell index; index 0 is an empty (black) cell.
  localparam logic [7:0] PALETTE [8] = '{8'h00, 8'hE0, 8'h1C, 8'h03,
                                         8'hFC, 8'hE3, 8'h1F, 8'hF4};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/playfield_render_ctrl_grid_axis_tracker.sv
// Follows the beam along one axis, giving the current grid index, offset
// within the cell, whether the beam is inside the grid, and whether it is on a grid line.
module playfield_render_ctrl_grid_axis_tracker
  import playfield_render_ctrl_pkg::*;
#(
  parameter int POS_W  = 11,
  parameter int ORIGIN = 0,
  parameter int COUNT  = 1
) (
  input  logic             vclk,
  input  logic             reset,
  input  logic             step,
  input  logic [POS_W-1:0] pos,
  output logic [IDX_W-1:0] idx,
  output logic [SUB_W-1:0] sub,
  output logic             in_range,
  output logic             on_line
);

  localparam logic [POS_W-1:0] POS_LO   = POS_W'(ORIGIN);
  localparam logic [POS_W-1:0] POS_HI   = POS_W'(ORIGIN + COUNT * PITCH);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PITCH - 1);

  logic [IDX_W-1:0] idx_q, idx_n;
  logic [SUB_W-1:0] sub_q, sub_n;

  // On a step the outputs already reflect the position being presented,
  // so downstream logic sees the cell for the current pos without lag.
  always_comb begin
    idx_n = idx_q;
    sub_n = sub_q;
    if (pos == POS_LO) begin
      idx_n = '0;
      sub_n = '0;
    end else if (sub_q == SUB_LAST) begin
      idx_n = idx_q + IDX_W'(1);
      sub_n = '0;
    end else begin
      sub_n = sub_q + SUB_W'(1);
    end
  end

  always_ff @(posedge vclk) begin
    if (reset) begin
      idx_q <= '0;
      sub_q <= '0;
    end else if (step) begin
      idx_q <= idx_n;
      sub_q <= sub_n;
    end
  end

  assign idx      = step ? idx_n : idx_q;
  assign sub      = step ? sub_n : sub_q;
  assign in_range = (pos >= POS_LO) && (pos <= POS_HI);
  assign on_line  = in_range && (sub == '0);

endmodule

// File: rtl/playfield_render_ctrl.sv
// Playfield renderer: prefetches each cell row from the shared board RAM into
// a line buffer during the left margin, then emits grid lines and cell colours.
module playfield_render_ctrl
  import playfield_render_ctrl_pkg::*;
(
  input  logic        vclk,
  input  logic        reset,
  input  logic        sw_grid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        ram_rd_en,
  output logic [8:0]  ram_addr,
  input  logic        ram_grant,
  input  logic [2:0]  ram_rd_data,
  output logic        fetch_busy,
  output logic        underrun,
  output logic [7:0]  pixel
);

  logic [IDX_W-1:0]  col, row;
  logic [SUB_W-1:0]  hsub, vsub;
  logic              h_in, v_in, h_on, v_on;

  fetch_state_t      state, state_n;
  logic [FCOL_W-1:0] fcol, fcol_n, addr_col, pend_col;
  logic              pend_valid, rd_en, clear, abort, start, at_x0;
  logic [2:0]        linebuf [COLS];
  logic [2:0]        cell_color_idx;
  logic [7:0]        pixel_n;

  playfield_render_ctrl_grid_axis_tracker #(.POS_W(11), .ORIGIN(X0), .COUNT(COLS)) u_h_axis (
    .vclk     (vclk),
    .reset    (reset),
    .step     (1'b1),
    .pos      (hcount),
    .idx      (col),
    .sub      (hsub),
    .in_range (h_in),
    .on_line  (h_on)
  );

  playfield_render_ctrl_grid_axis_tracker #(.POS_W(10), .ORIGIN(Y0), .COUNT(ROWS)) u_v_axis (
    .vclk     (vclk),
    .reset    (reset),
    .step     (hcount == '0),
    .pos      (vcount),
    .idx      (row),
    .sub      (vsub),
    .in_range (v_in),
    .on_line  (v_on)
  );

  assign at_x0 = (hcount == 11'(X0));
  assign start = (hcount == 11'(FETCH_H)) && v_in && (vsub == '0) && (row < IDX_W'(ROWS));

  // The first request is issued in the trigger cycle itself, so a fully
  // granted fetch occupies exactly COLS cycles starting at FETCH_H.
  always_comb begin
    state_n  = state;
    fcol_n   = fcol;
    addr_col = fcol;
    rd_en    = 1'b0;
    clear    = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear    = 1'b1;
          rd_en    = 1'b1;
          addr_col = '0;
          fcol_n   = ram_grant ? FCOL_W'(1) : '0;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (at_x0) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          rd_en = 1'b1;
          if (ram_grant) begin
            if (fcol == FCOL_W'(COLS - 1)) state_n = DRAIN;
            else                           fcol_n  = fcol + FCOL_W'(1);
          end
        end
      end
      DRAIN: begin
        abort   = at_x0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ram_rd_en  = rd_en;
  assign ram_addr   = rd_en ? (9'(row) * 9'(COLS) + 9'(addr_col)) : '0;
  assign fetch_busy = (state != IDLE);

  always_comb begin
    cell_color_idx = '0;
    if (col < IDX_W'(COLS)) cell_color_idx = linebuf[col[FCOL_W-1:0]];
    pixel_n = '0;
    if (sw_grid && h_in && v_in && (h_on || v_on))
      pixel_n = GRID_COLOR;
    else if (h_in && v_in && (col < IDX_W'(COLS)) && (row < IDX_W'(ROWS)) &&
             (hsub != '0) && (vsub != '0))
      pixel_n = PALETTE[cell_color_idx];
  end

  // RAM data lands one cycle after its grant; the column is captured with it.
  always_ff @(posedge vclk) begin
    if (reset) begin
      state      <= IDLE;
      fcol       <= '0;
      pend_valid <= 1'b0;
      pend_col   <= '0;
      underrun   <= 1'b0;
      pixel      <= '0;
      for (int i = 0; i < COLS; i++) linebuf[i] <= '0;
    end else begin
      state      <= state_n;
      fcol       <= fcol_n;
      pend_valid <= rd_en && ram_grant;
      pend_col   <= addr_col;
      underrun   <= abort;
      pixel      <= pixel_n;
      if (clear) begin
        for (int i = 0; i < COLS; i++) linebuf[i] <= '0;
      end else if (pend_valid) begin
        linebuf[pend_col] <= ram_rd_data;
      end
    end
  end

endmodule
